fprint_compare_sequencer: RTL and testbench

Drains the per-core monitor FIFOs of a redundant core group (DMR or TMR) in lock-step. Each result is an {address, data} fingerprint pair. For every round the block reads the pair from each FIFO, pops the entries, and compares them across cores. It reports mismatches, a stalled-core timeout and running statistics through an Avalon-MM CSR slave and an interrupt. It sits between the monitor FIFOs' read ports and the fault-handling processor, replacing software polling.

---
 rtl/fprint_compare_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_fprint_compare_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fprint_compare_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fprint_compare_sequencer
// Brief   : Lock-step drain and cross-compare of redundant-core fingerprint
//           FIFOs (DMR/TMR) with CSR statistics, timeout and interrupt.
// Revision: 1.0 - initial release
// ============================================================================
module fprint_compare_sequencer #(
  parameter int NUM_FIFOS         = 2,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDRESS_WIDTH     = 10,
  parameter int CSR_ADDRESS_WIDTH = 3,
  parameter int TIMEOUT_DEFAULT   = 1024
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_FIFOS-1:0]              fifo_empty,
  output logic [NUM_FIFOS-1:0]              fifo_read,
  output logic                              fifo_address,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0]   fifo_readdata,
  input  logic [NUM_FIFOS-1:0]              fifo_waitrequest,
  input  logic [CSR_ADDRESS_WIDTH-1:0]      csr_address,
  input  logic                              csr_read,
  input  logic                              csr_write,
  input  logic [DATA_WIDTH-1:0]             csr_writedata,
  output logic [DATA_WIDTH-1:0]             csr_readdata,
  output logic                              irq
);

  localparam int c_PW = ADDRESS_WIDTH + DATA_WIDTH;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_RD_ADDR = 3'd1;
  localparam logic [2:0] c_RD_DATA = 3'd2;
  localparam logic [2:0] c_SETTLE  = 3'd3;
  localparam logic [2:0] c_COMPARE = 3'd4;

  localparam logic [CSR_ADDRESS_WIDTH-1:0] c_CSR_CTRL    = CSR_ADDRESS_WIDTH'(0);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] c_CSR_STATUS  = CSR_ADDRESS_WIDTH'(1);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] c_CSR_MATCH   = CSR_ADDRESS_WIDTH'(2);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] c_CSR_MISM    = CSR_ADDRESS_WIDTH'(3);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] c_CSR_TIMEOUT = CSR_ADDRESS_WIDTH'(4);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] c_CSR_FFADDR  = CSR_ADDRESS_WIDTH'(5);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] c_CSR_CLRCNT  = CSR_ADDRESS_WIDTH'(6);

  logic [2:0]               r_state;
  logic [2:0]               w_state_next;
  logic [NUM_FIFOS-1:0]     r_done;
  logic [ADDRESS_WIDTH-1:0] r_addr_q [NUM_FIFOS];
  logic [DATA_WIDTH-1:0]    r_data_q [NUM_FIFOS];
  logic                     r_enable;
  logic [DATA_WIDTH-1:0]    r_timeout;
  logic [DATA_WIDTH-1:0]    r_to_cnt;
  logic [DATA_WIDTH-1:0]    r_match_cnt;
  logic [DATA_WIDTH-1:0]    r_mis_cnt;
  logic                     r_mis_sticky;
  logic                     r_to_sticky;
  logic [1:0]               r_fault_idx;
  logic [ADDRESS_WIDTH-1:0] r_ff_addr;

  logic [NUM_FIFOS-1:0]     w_accept;
  logic                     w_all_done;
  logic                     w_all_ready;
  logic                     w_partial;
  logic                     w_match;
  logic [1:0]               w_idx;
  logic [c_PW-1:0]          w_pair [NUM_FIFOS];

  assign w_accept    = fifo_read & ~fifo_waitrequest;
  assign w_all_done  = &(r_done | w_accept);
  assign w_all_ready = ~|fifo_empty;
  assign w_partial   = (|fifo_empty) & ~(&fifo_empty);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= c_IDLE;
    else          r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:    if (r_enable && w_all_ready) w_state_next = c_RD_ADDR;
      c_RD_ADDR: if (w_all_done) w_state_next = c_RD_DATA;
      c_RD_DATA: if (w_all_done) w_state_next = c_SETTLE;
      c_SETTLE:  w_state_next = c_COMPARE;
      c_COMPARE: w_state_next = c_IDLE;
      default:   w_state_next = c_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    fifo_read    = '0;
    fifo_address = 1'b0;
    case (r_state)
      c_RD_ADDR: fifo_read = ~r_done;
      c_RD_DATA: begin
        fifo_read    = ~r_done;
        fifo_address = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-FIFO handshake tracking and capture; each FIFO finishes independently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= '0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
        r_addr_q[i] <= '0;
        r_data_q[i] <= '0;
      end
    end else begin
      if ((r_state == c_RD_ADDR) || (r_state == c_RD_DATA))
        r_done <= w_all_done ? '0 : (r_done | w_accept);
      else
        r_done <= '0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
        if (w_accept[i] && (r_state == c_RD_ADDR))
          r_addr_q[i] <= fifo_readdata[i*DATA_WIDTH +: ADDRESS_WIDTH];
        if (w_accept[i] && (r_state == c_RD_DATA))
          r_data_q[i] <= fifo_readdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_pair
    assign w_pair[gi] = {r_addr_q[gi], r_data_q[gi]};
  end

  if (NUM_FIFOS == 3) begin : g_tmr
    logic w_e01, w_e02, w_e12;
    assign w_e01 = (w_pair[0] == w_pair[1]);
    assign w_e02 = (w_pair[0] == w_pair[2]);
    assign w_e12 = (w_pair[1] == w_pair[2]);
    assign w_match = w_e01 & w_e02;
    always_comb begin
      w_idx = 2'd3;
      if (w_e12 && !w_e01)      w_idx = 2'd0;
      else if (w_e02 && !w_e01) w_idx = 2'd1;
      else if (w_e01 && !w_e02) w_idx = 2'd2;
    end
  end else begin : g_dmr
    assign w_match = (w_pair[0] == w_pair[1]);
    assign w_idx   = 2'd3;
  end

  logic                  w_cmp_match;
  logic                  w_cmp_mis;
  logic                  w_ctrl_wr;
  logic                  w_sticky_clr;
  logic                  w_to_run;
  logic                  w_to_set;
  logic [DATA_WIDTH:0]   w_to_next;

  assign w_cmp_match  = (r_state == c_COMPARE) &&  w_match;
  assign w_cmp_mis    = (r_state == c_COMPARE) && !w_match;
  assign w_ctrl_wr    = csr_write && (csr_address == c_CSR_CTRL);
  assign w_sticky_clr = w_ctrl_wr && csr_writedata[1];
  assign w_to_next    = {1'b0, r_to_cnt} + (DATA_WIDTH+1)'(1);
  assign w_to_run     = (r_state == c_IDLE) && r_enable && w_partial && (r_timeout != '0);
  assign w_to_set     = w_to_run && (w_to_next >= {1'b0, r_timeout});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable     <= 1'b0;
      r_timeout    <= DATA_WIDTH'(TIMEOUT_DEFAULT);
      r_to_cnt     <= '0;
      r_match_cnt  <= '0;
      r_mis_cnt    <= '0;
      r_mis_sticky <= 1'b0;
      r_to_sticky  <= 1'b0;
      r_fault_idx  <= '0;
      r_ff_addr    <= '0;
    end else begin
      if (w_ctrl_wr) r_enable <= csr_writedata[0];
      if (csr_write && (csr_address == c_CSR_TIMEOUT)) r_timeout <= csr_writedata;

      if (w_to_run) begin
        if (r_to_cnt < r_timeout) r_to_cnt <= w_to_next[DATA_WIDTH-1:0];
      end else begin
        r_to_cnt <= '0;
      end

      if (csr_write && (csr_address == c_CSR_CLRCNT)) begin
        r_match_cnt <= '0;
        r_mis_cnt   <= '0;
      end else begin
        if (w_cmp_match && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + DATA_WIDTH'(1);
        if (w_cmp_mis   && (r_mis_cnt   != '1)) r_mis_cnt   <= r_mis_cnt + DATA_WIDTH'(1);
      end

      // A new fault in the same cycle as a clear wins and becomes the first fault
      if (w_cmp_mis)         r_mis_sticky <= 1'b1;
      else if (w_sticky_clr) r_mis_sticky <= 1'b0;
      if (w_to_set)          r_to_sticky  <= 1'b1;
      else if (w_sticky_clr) r_to_sticky  <= 1'b0;

      if (w_cmp_mis && (!r_mis_sticky || w_sticky_clr)) begin
        r_fault_idx <= w_idx;
        r_ff_addr   <= r_addr_q[0];
      end else if (w_sticky_clr) begin
        r_fault_idx <= '0;
      end
    end
  end

  assign irq = r_mis_sticky | r_to_sticky;

  always_comb begin
    csr_readdata = '0;
    if (csr_read) begin
      case (csr_address)
        c_CSR_CTRL:    csr_readdata[0] = r_enable;
        c_CSR_STATUS: begin
          csr_readdata[1:0] = r_fault_idx;
          csr_readdata[2]   = r_mis_sticky;
          csr_readdata[3]   = r_to_sticky;
          csr_readdata[6:4] = r_state;
          csr_readdata[7]   = (r_state != c_IDLE);
        end
        c_CSR_MATCH:   csr_readdata = r_match_cnt;
        c_CSR_MISM:    csr_readdata = r_mis_cnt;
        c_CSR_TIMEOUT: csr_readdata = r_timeout;
        c_CSR_FFADDR:  csr_readdata[ADDRESS_WIDTH-1:0] = r_ff_addr;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fprint_compare_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fprint_compare_sequencer
// Brief   : Directed bench driving a DMR and a TMR instance from one FIFO model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fprint_compare_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Shared FIFO model: three FIFOs, routed to the TMR or the DMR instance
  logic        sel_tmr = 1'b0;
  logic        m_clr = 1'b0;
  logic [9:0]  m_addr [3];
  logic [31:0] m_data [3];
  int          m_avail [3];
  int          m_wa [3];
  int          m_wd [3];
  int          m_pops [3];
  int          m_areads [3];
  int          m_aws [3];
  int          m_dws [3];
  logic [2:0]  m_empty, m_wait, m_read;
  logic        m_adr;
  logic [95:0] m_rdata;

  logic [1:0]  d_read;
  logic        d_addr;
  logic [31:0] d_csr_rdata;
  logic        d_irq;
  logic        d_csr_read = 1'b0, d_csr_write = 1'b0;
  logic [2:0]  t_read;
  logic        t_addr;
  logic [31:0] t_csr_rdata;
  logic        t_irq;
  logic        t_csr_read = 1'b0, t_csr_write = 1'b0;
  logic [2:0]  csr_address = '0;
  logic [31:0] csr_writedata = '0;

  assign m_read = sel_tmr ? t_read : {1'b0, d_read};
  assign m_adr  = sel_tmr ? t_addr : d_addr;

  always_comb begin
    m_empty = '0;
    m_wait  = '0;
    m_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      m_empty[i] = (m_pops[i] >= m_avail[i]);
      m_wait[i]  = m_adr ? (m_dws[i] < m_wd[i]) : (m_aws[i] < m_wa[i]);
      m_rdata[i*32 +: 32] = m_adr ? m_data[i] : {22'd0, m_addr[i]};
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_clr) begin
        m_pops[i] <= 0; m_areads[i] <= 0; m_aws[i] <= 0; m_dws[i] <= 0;
      end else if (m_read[i]) begin
        if (m_adr) begin
          if (m_dws[i] < m_wd[i]) m_dws[i] <= m_dws[i] + 1;
          else                    m_pops[i] <= m_pops[i] + 1;
        end else begin
          if (m_aws[i] < m_wa[i]) m_aws[i] <= m_aws[i] + 1;
          else                    m_areads[i] <= m_areads[i] + 1;
        end
      end
    end
  end

  fprint_compare_sequencer #(.NUM_FIFOS(2)) dut_d (
    .clk(clk), .reset_n(reset_n),
    .fifo_empty(sel_tmr ? 2'b11 : m_empty[1:0]),
    .fifo_read(d_read), .fifo_address(d_addr),
    .fifo_readdata(m_rdata[63:0]), .fifo_waitrequest(m_wait[1:0]),
    .csr_address(csr_address), .csr_read(d_csr_read), .csr_write(d_csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(d_csr_rdata), .irq(d_irq)
  );

  fprint_compare_sequencer #(.NUM_FIFOS(3)) dut_t (
    .clk(clk), .reset_n(reset_n),
    .fifo_empty(sel_tmr ? m_empty : 3'b111),
    .fifo_read(t_read), .fifo_address(t_addr),
    .fifo_readdata(m_rdata), .fifo_waitrequest(m_wait),
    .csr_address(csr_address), .csr_read(t_csr_read), .csr_write(t_csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(t_csr_rdata), .irq(t_irq)
  );

  task automatic csr_wr(input bit tmr, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_writedata = d;
    if (tmr) t_csr_write = 1'b1; else d_csr_write = 1'b1;
    @(negedge clk);
    d_csr_write = 1'b0; t_csr_write = 1'b0;
  endtask

  task automatic csr_rd(input bit tmr, input logic [2:0] a, output logic [31:0] d);
    csr_address = a;
    if (tmr) t_csr_read = 1'b1; else d_csr_read = 1'b1;
    #1;
    d = tmr ? t_csr_rdata : d_csr_rdata;
    d_csr_read = 1'b0; t_csr_read = 1'b0;
  endtask

  task automatic model_load(input bit tmr, input logic [9:0] a0, a1, a2,
                            input logic [31:0] d0, d1, d2, input int av0, av1, av2,
                            input int wa1, input int wd1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin m_avail[i] = 0; m_wa[i] = 0; m_wd[i] = 0; end
    m_clr = 1'b1;
    @(negedge clk);
    m_clr = 1'b0;
    sel_tmr = tmr;
    m_addr[0] = a0; m_addr[1] = a1; m_addr[2] = a2;
    m_data[0] = d0; m_data[1] = d1; m_data[2] = d2;
    m_wa[1] = wa1; m_wd[1] = wd1;
    m_avail[0] = av0; m_avail[1] = av1; m_avail[2] = av2;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    @(negedge clk);
    tests_run++;
    if (d_read !== 2'b00 || d_addr !== 1'b0 || d_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: read=%b addr=%b irq=%b, required 00/0/0", d_read, d_addr, d_irq);
    end
    csr_rd(0, 3'd1, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_status: got %h, required 0", v); end
    csr_rd(0, 3'd4, v);
    tests_run++;
    if (v !== 32'd1024) begin tests_failed++; $display("FAIL reset_timeout: got %0d, required 1024", v); end
    csr_rd(0, 3'd0, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h, required 0", v); end
  endtask

  task automatic test_dmr_match();
    logic [31:0] v;
    int busy = 0;
    bit seen = 0;
    model_load(0, 10'h010, 10'h010, 10'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1, 1, 0, 0, 0);
    csr_wr(0, 3'd0, 32'h1);
    for (int k = 0; k < 20; k++) begin
      if (k != 0) @(negedge clk);
      csr_rd(0, 3'd1, v);
      if (v[7]) begin busy++; seen = 1; end
      else if (seen) break;
    end
    tests_run++;
    if (busy !== 4) begin tests_failed++; $display("FAIL dmr_round_len: busy %0d cycles, required 4", busy); end
    tests_run++;
    if (m_areads[0] !== 1 || m_areads[1] !== 1 || m_pops[0] !== 1 || m_pops[1] !== 1) begin
      tests_failed++;
      $display("FAIL dmr_reads: areads=%0d,%0d pops=%0d,%0d, required 1,1 1,1",
               m_areads[0], m_areads[1], m_pops[0], m_pops[1]);
    end
    csr_rd(0, 3'd2, v);
    tests_run++;
    if (v !== 32'd1) begin tests_failed++; $display("FAIL dmr_match_count: got %0d, required 1", v); end
    tests_run++;
    if (d_irq !== 1'b0) begin tests_failed++; $display("FAIL dmr_irq: got %b, required 0", d_irq); end
  endtask

  task automatic test_tmr_mismatch();
    logic [31:0] v;
    model_load(1, 10'h020, 10'h020, 10'h020, 32'h11, 32'h11, 32'h22, 1, 1, 1, 0, 0);
    csr_wr(1, 3'd0, 32'h1);
    for (int k = 0; k < 30 && t_irq !== 1'b1; k++) @(negedge clk);
    csr_rd(1, 3'd3, v);
    tests_run++;
    if (v !== 32'd1) begin tests_failed++; $display("FAIL tmr_mismatch_count: got %0d, required 1", v); end
    csr_rd(1, 3'd1, v);
    tests_run++;
    if (v[2:0] !== 3'b110 || t_irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL tmr_fault: status[2:0]=%b irq=%b, required 110/1", v[2:0], t_irq);
    end
    csr_rd(1, 3'd5, v);
    tests_run++;
    if (v !== 32'h020) begin tests_failed++; $display("FAIL tmr_ff_addr: got %h, required 020", v); end
    csr_wr(1, 3'd0, 32'h3);
    csr_rd(1, 3'd1, v);
    tests_run++;
    if (v[3:0] !== 4'h0 || t_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmr_clear: status[3:0]=%h irq=%b, required 0/0", v[3:0], t_irq);
    end
    csr_rd(1, 3'd0, v);
    tests_run++;
    if (v !== 32'h1) begin tests_failed++; $display("FAIL tmr_ctrl_after_clear: got %h, required 1", v); end
  endtask

  task automatic test_skew();
    logic [31:0] v;
    int r0 = 0, r1 = 0, first_data = -1;
    model_load(0, 10'h030, 10'h030, 10'h0, 32'h5A5A, 32'h5A5A, 32'h0, 1, 1, 0, 3, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (d_read[0] && !d_addr) r0++;
      if (d_read[1] && !d_addr) r1++;
      if (d_addr && first_data < 0) first_data = k;
    end
    tests_run++;
    if (r0 !== 1 || r1 !== 4) begin
      tests_failed++;
      $display("FAIL skew_addr_reads: fifo0 %0d fifo1 %0d cycles, required 1 and 4", r0, r1);
    end
    tests_run++;
    if (first_data !== 4) begin tests_failed++; $display("FAIL skew_data_start: cycle %0d, required 4", first_data); end
    tests_run++;
    if (m_areads[0] !== 1 || m_pops[0] !== 1 || m_pops[1] !== 1) begin
      tests_failed++;
      $display("FAIL skew_pops: areads0=%0d pops=%0d,%0d, required 1 1,1", m_areads[0], m_pops[0], m_pops[1]);
    end
    csr_rd(0, 3'd2, v);
    tests_run++;
    if (v !== 32'd2) begin tests_failed++; $display("FAIL skew_match_count: got %0d, required 2", v); end
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    csr_wr(0, 3'd4, 32'd8);
    model_load(0, 10'h0, 10'h0, 10'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 7) begin
        tests_run++;
        if (d_irq !== 1'b0) begin tests_failed++; $display("FAIL timeout_early: irq=%b at cycle 7, required 0", d_irq); end
      end
    end
    csr_rd(0, 3'd1, v);
    tests_run++;
    if (d_irq !== 1'b1 || v[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_set: irq=%b sticky=%b at cycle 8, required 1/1", d_irq, v[3]);
    end
    tests_run++;
    if (m_areads[0] !== 0 || m_pops[0] !== 0) begin
      tests_failed++;
      $display("FAIL timeout_no_reads: areads=%0d pops=%0d, required 0/0", m_areads[0], m_pops[0]);
    end
    m_avail[0] = 0;
    csr_wr(0, 3'd0, 32'h3);
    csr_wr(0, 3'd4, 32'd0);
  endtask

  task automatic test_reset_mid_round();
    logic [31:0] v;
    int stray = 0;
    bit hit = 0;
    model_load(0, 10'h040, 10'h040, 10'h0, 32'h1, 32'h1, 32'h0, 1, 1, 0, 0, 5);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_addr && d_read == 2'b10) begin hit = 1; break; end
    end
    tests_run++;
    if (!hit) begin tests_failed++; $display("FAIL rst_reach_rd_data: not observed, required within 20 cycles"); end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (d_read !== 2'b00 || d_addr !== 1'b0 || d_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async_outputs: read=%b addr=%b irq=%b, required 00/0/0", d_read, d_addr, d_irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    csr_rd(0, 3'd2, v);
    tests_run++;
    if (v !== 32'd0) begin tests_failed++; $display("FAIL rst_match_count: got %0d, required 0", v); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (d_read != 2'b00) stray++;
    end
    tests_run++;
    if (stray !== 0 || m_pops[1] !== 0) begin
      tests_failed++;
      $display("FAIL rst_no_reads: stray=%0d pops1=%0d, required 0/0", stray, m_pops[1]);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] v;
    csr_wr(0, 3'd0, 32'h1);
    model_load(0, 10'h050, 10'h050, 10'h0, 32'h7, 32'h7, 32'h0, 1, 1, 0, 0, 0);
    repeat (10) @(negedge clk);
    force dut_d.r_mis_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_d.r_mis_cnt;
    model_load(0, 10'h060, 10'h060, 10'h0, 32'h1, 32'h2, 32'h0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 30 && d_irq !== 1'b1; k++) @(negedge clk);
    csr_rd(0, 3'd3, v);
    tests_run++;
    if (v !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL sat_mismatch_count: got %h, required ffffffff", v); end
    csr_rd(0, 3'd1, v);
    tests_run++;
    if (v[2:0] !== 3'b111 || d_irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_fault: status[2:0]=%b irq=%b, required 111/1", v[2:0], d_irq);
    end
    csr_wr(0, 3'd6, 32'h0);
    csr_rd(0, 3'd2, v);
    tests_run++;
    if (v !== 32'd0) begin tests_failed++; $display("FAIL clr_match_count: got %0d, required 0", v); end
    csr_rd(0, 3'd3, v);
    tests_run++;
    if (v !== 32'd0) begin tests_failed++; $display("FAIL clr_mismatch_count: got %0d, required 0", v); end
    csr_rd(0, 3'd6, v);
    tests_run++;
    if (v !== 32'd0) begin tests_failed++; $display("FAIL csr6_read: got %h, required 0", v); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_addr[i] = '0; m_data[i] = '0; m_avail[i] = 0; m_wa[i] = 0; m_wd[i] = 0;
    end
    m_clr = 1'b1;
    repeat (3) @(negedge clk);
    m_clr = 1'b0;
    test_reset();
    reset_n = 1'b1;
    test_reset();
    test_dmr_match();
    test_tmr_mismatch();
    test_skew();
    test_timeout();
    test_reset_mid_round();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
